// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM link (generator and duty measurement).
package pwm_pkg;

    localparam int PWM_DUTY_W  = 11;
    localparam int PWM_PER_W   = 12;
    localparam int PWM_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_meas_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM pin, plus one delay flop
// for edge detection. Level and edge flags are all taken from the
// synchronized side, so they are mutually consistent in every cycle.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    // Shift the pin through s1 (metastability catch), s2 (stable) and s3 (previous level).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign lvl_o  = s2_q;
    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_duty_meas.sv
// Receive side of the PWM link: measures high time and rise-to-rise period
// of the incoming waveform and reports a line stuck high or low.
//
// Output strobe: vld is a valid-only pulse (no ready). It is high for exactly
// one clock whenever duty/period/stuck_hi/stuck_lo take new values; those
// outputs are stable in that cycle and hold until the next pulse. The
// consumer must sample them when vld is high or any time before the next one.
module pwm_duty_meas
    import pwm_pkg::*;
#(
    parameter int DUTY_W  = PWM_DUTY_W,
    parameter int PER_W   = PWM_PER_W,
    parameter int TIMEOUT = PWM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PWM_in,
    output logic [DUTY_W-1:0] duty,
    output logic [PER_W-1:0]  period,
    output logic              vld,
    output logic              stuck_hi,
    output logic              stuck_lo,
    output logic [1:0]        state_dbg
);

    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
    localparam logic [DUTY_W:0]   HI_MAX    = '1;
    localparam logic [PER_W-1:0]  PER_MAX   = '1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic lvl, rise, fall;

    pwm_edge_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_i  (PWM_in),
        .lvl_o  (lvl),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_meas_state_t    state_q;
    logic [PER_W-1:0]   per_cnt_q;
    logic [DUTY_W:0]    hi_cnt_q;
    logic [IDLE_W-1:0]  idle_cnt_q;
    logic [DUTY_W-1:0]  duty_q;
    logic [PER_W-1:0]   period_q;
    logic               vld_q;
    logic               stuck_hi_q;
    logic               stuck_lo_q;

    logic [PER_W-1:0]   per_inc;
    logic [DUTY_W:0]    hi_inc;
    logic [DUTY_W-1:0]  duty_sat;
    logic [IDLE_W-1:0]  idle_cnt_d;
    logic               any_edge;
    logic               timeout_hit;

    // Saturating increments, duty clamp and the edge-starved timeout detector.
    always_comb begin
        any_edge    = rise | fall;
        per_inc     = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + PER_W'(1);
        hi_inc      = (hi_cnt_q == HI_MAX) ? hi_cnt_q : hi_cnt_q + (DUTY_W+1)'(1);
        duty_sat    = (hi_cnt_q > {1'b0, DUTY_MAX}) ? DUTY_MAX : hi_cnt_q[DUTY_W-1:0];
        idle_cnt_d  = any_edge ? '0 :
                      (idle_cnt_q == IDLE_LAST) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
        // An edge in the same cycle always wins over the timeout.
        timeout_hit = !any_edge && (idle_cnt_q == IDLE_LAST) && !stuck_hi_q && !stuck_lo_q;
    end

    // Measurement FSM with counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            idle_cnt_q <= '0;
            duty_q     <= '0;
            period_q   <= '0;
            vld_q      <= 1'b0;
            stuck_hi_q <= 1'b0;
            stuck_lo_q <= 1'b0;
        end else begin
            vld_q      <= 1'b0;
            idle_cnt_q <= idle_cnt_d;
            if (timeout_hit) begin
                // No edges for TIMEOUT clocks: report 0% or 100% and rearm from IDLE.
                state_q  <= IDLE;
                period_q <= '0;
                vld_q    <= 1'b1;
                if (lvl) begin
                    duty_q     <= DUTY_MAX;
                    stuck_hi_q <= 1'b1;
                end else begin
                    duty_q     <= '0;
                    stuck_lo_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        // The first rise only starts a measurement; the partial period before it is dropped.
                        if (rise) begin
                            per_cnt_q <= PER_W'(1);
                            hi_cnt_q  <= (DUTY_W+1)'(1);
                            state_q   <= HIGH;
                        end
                    end
                    HIGH: begin
                        per_cnt_q <= per_inc;
                        if (fall) begin
                            state_q <= LOW;
                        end else begin
                            hi_cnt_q <= hi_inc;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            duty_q     <= duty_sat;
                            period_q   <= per_cnt_q;
                            vld_q      <= 1'b1;
                            stuck_hi_q <= 1'b0;
                            stuck_lo_q <= 1'b0;
                            per_cnt_q  <= PER_W'(1);
                            hi_cnt_q   <= (DUTY_W+1)'(1);
                            state_q    <= HIGH;
                        end else begin
                            per_cnt_q <= per_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign duty      = duty_q;
    assign period    = period_q;
    assign vld       = vld_q;
    assign stuck_hi  = stuck_hi_q;
    assign stuck_lo  = stuck_lo_q;
    assign state_dbg = state_q;

endmodule
